alu_result_fifo: RTL and testbench

//   Downstream stage of the pipelined 4-bit ALU. It captures every result beat flagged by the ALU's
//   out_valid, packs result + flags into an 8-bit entry, and buffers entries in a first-word-fall-through

---
 rtl/alu_result_fifo.sv | 100 ++++++++++
 tb/tb_alu_result_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result buffer behind the pipelined 4-bit ALU: packs each result beat with its flags into a
// first-word-fall-through FIFO, drops (and counts) beats that arrive while full, and keeps sticky flags.
module alu_result_fifo #(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        Result,
    input  logic              SLT_Flag,
    input  logic              Zero_Flag,
    input  logic              Carry_Flag,
    input  logic              Overflow_Flag,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [ADDR_W:0]   fill_level,
    output logic              full,
    output logic              empty,
    input  logic              sticky_clr,
    output logic [3:0]        sticky_flags,
    output logic [CNT_W-1:0]  drop_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [3:0]        beat_flags;
    logic [7:0]        entry;
    logic              push;
    logic              pop;
    logic              drop;

    assign beat_flags = {Overflow_Flag, Carry_Flag, Zero_Flag, SLT_Flag};
    assign entry      = {beat_flags, Result};

    // Output handshake: an entry transfers on a cycle where out_valid && out_ready; while
    // out_ready is low the head (out_valid, out_data) holds and is never retracted.
    // The input side has no backpressure: a beat that finds the FIFO full and not popping is lost.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    assign fill_level = count;
    assign full       = (count == DEPTH_L);
    assign empty      = (count == '0);
    assign out_valid  = ~empty;
    assign out_data   = mem[rd_ptr];

    // Storage is deliberately left unreset; out_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Dropped beats still contribute flags; a clear coinciding with a beat keeps that beat's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= in_valid ? beat_flags : 4'b0000;
        end else if (in_valid) begin
            sticky_flags <= sticky_flags | beat_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed scenarios plus random traffic compared
// against a queue-based model of the buffer, sticky flags and drop counter.
module tb_alu_result_fifo;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] Result;
    logic       SLT_Flag;
    logic       Zero_Flag;
    logic       Carry_Flag;
    logic       Overflow_Flag;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] fill_level;
    logic       full;
    logic       empty;
    logic       sticky_clr;
    logic [3:0] sticky_flags;
    logic [7:0] drop_count;

    logic [7:0] exp_q[$];
    logic [3:0] exp_sticky;
    logic [7:0] exp_drops;
    int         n_checks;
    int         n_fail;

    alu_result_fifo #(.ADDR_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Result(Result),
        .SLT_Flag(SLT_Flag), .Zero_Flag(Zero_Flag), .Carry_Flag(Carry_Flag),
        .Overflow_Flag(Overflow_Flag), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .fill_level(fill_level), .full(full), .empty(empty),
        .sticky_clr(sticky_clr), .sticky_flags(sticky_flags), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid = 1'b0; Result = 4'h0; SLT_Flag = 1'b0; Zero_Flag = 1'b0;
        Carry_Flag = 1'b0; Overflow_Flag = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_sticky = 4'h0;
        exp_drops  = 8'h00;
    endtask

    // Drive one cycle from a negedge; the model applies the FIFO rules at the posedge.
    // d is the packed entry {Overflow,Carry,Zero,SLT,Result}.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic do_pop;
        logic do_push;
        in_valid = v; Result = d[3:0]; SLT_Flag = d[4]; Zero_Flag = d[5];
        Carry_Flag = d[6]; Overflow_Flag = d[7]; out_ready = rdy; sticky_clr = clr;
        do_pop  = (exp_q.size() != 0) && rdy;
        do_push = v && ((exp_q.size() < DEPTH) || do_pop);
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        if (v && !do_push && exp_drops != 8'hFF) exp_drops = exp_drops + 8'd1;
        if (clr) exp_sticky = v ? d[7:4] : 4'h0;
        else if (v) exp_sticky = exp_sticky | d[7:4];
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        n_checks++; if (sticky_flags !== 4'h0) begin n_fail++; $display("FAIL reset_sticky got=%h exp=0", sticky_flags); end
        n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
    endtask

    task automatic test_single_write();
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL single_data got=%h exp=05", out_data); end
        n_checks++; if (fill_level !== 3'd1) begin n_fail++; $display("FAIL single_fill got=%0d exp=1", fill_level); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow_drop();
        logic [7:0] want [4];
        want = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) cycle(1'b1, want[i], 1'b0, 1'b0);
        cycle(1'b1, 8'h0F, 1'b0, 1'b0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", full); end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drops got=%0d exp=1", drop_count); end
        n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL ovf_head_hold got=%h exp=01", out_data); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data !== want[i] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL ovf_drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, want[i]);
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] prior_drops;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        prior_drops = exp_drops;
        cycle(1'b1, 8'h09, 1'b1, 1'b0);
        n_checks++; if (fill_level !== 3'd4) begin n_fail++; $display("FAIL fpp_fill got=%0d exp=4", fill_level); end
        n_checks++; if (drop_count !== prior_drops) begin n_fail++; $display("FAIL fpp_drops got=%0d exp=%0d", drop_count, prior_drops); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_data !== exp_q[0]) begin
                n_fail++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, out_data, exp_q[0]);
            end
            if (i == 3) begin
                n_checks++; if (out_data !== 8'h09) begin n_fail++; $display("FAIL fpp_last got=%h exp=09", out_data); end
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_sticky();
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL sticky_clear got=%b exp=0000", sticky_flags); end
        cycle(1'b1, 8'h43, 1'b1, 1'b0);
        cycle(1'b1, 8'h87, 1'b1, 1'b0);
        n_checks++; if (sticky_flags !== 4'b1100) begin n_fail++; $display("FAIL sticky_acc got=%b exp=1100", sticky_flags); end
        cycle(1'b1, 8'h20, 1'b1, 1'b1);
        n_checks++; if (sticky_flags !== 4'b0010) begin n_fail++; $display("FAIL sticky_clr_beat got=%b exp=0010", sticky_flags); end
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent [10];
        logic [7:0] got[$];
        apply_reset();
        for (int i = 0; i < 10; i++) sent[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 11; i++) begin
            if (out_valid === 1'b1) got.push_back(out_data);
            cycle(i < 10, (i < 10) ? sent[i] : 8'h00, 1'b1, 1'b0);
        end
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL stream_count got=%0d exp=10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL stream[%0d] got=%h exp=%h", i, got[i], sent[i]); end
        end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL stream_drops got=%0d exp=0", drop_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            n_checks++; if (out_valid !== (exp_q.size() != 0) || fill_level !== 3'(exp_q.size())
                            || full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
                n_fail++; $display("FAIL rand_status[%0d] got=v%b f%0d F%b E%b exp_fill=%0d", i, out_valid, fill_level, full, empty, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, out_data, exp_q[0]); end
            end
            n_checks++; if (sticky_flags !== exp_sticky || drop_count !== exp_drops) begin
                n_fail++; $display("FAIL rand_csr[%0d] got=%b/%0d exp=%b/%0d", i, sticky_flags, drop_count, exp_sticky, exp_drops);
            end
            cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end
    endtask

    task automatic test_drop_saturate();
        repeat (270) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL sat_model got=%0d exp=%0d", drop_count, exp_drops); end
        n_checks++; if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL sat_value got=%0d exp=255", drop_count); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL sat_full got=%b exp=1", full); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hF0 | 8'(i), 1'b0, 1'b0);
        n_checks++; if (fill_level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_fill got=%0d exp=3", fill_level); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_empty got=E%b v%b exp=E1 v0", empty, out_valid); end
        n_checks++; if (fill_level !== 3'd0) begin n_fail++; $display("FAIL mid_fill got=%0d exp=0", fill_level); end
        n_checks++; if (sticky_flags !== 4'h0 || drop_count !== 8'h00) begin
            n_fail++; $display("FAIL mid_csr got=%b/%0d exp=0000/0", sticky_flags, drop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        n_checks++; if (out_data !== 8'h3C || fill_level !== 3'd1) begin
            n_fail++; $display("FAIL mid_after got=%h/%0d exp=3c/1", out_data, fill_level);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_overflow_drop();
        test_full_push_pop();
        test_sticky();
        test_back_to_back();
        test_random();
        test_drop_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
